// File: rtl/rd_tid_alloc.sv
// -----------------------------------------------------------------------------
// rd_tid_alloc
// Read transaction-ID allocator sitting in front of the read reorder buffer.
// Every accepted AXI AR request is tagged with the next sequential tID (the
// same order in which the ROB retires), its ARID is parked in a per-tID table,
// and {tID, addr} is handed to tag compare. The number of outstanding tIDs is
// capped at MAX_OUTST so the downstream hit/miss FIFOs can never overflow.
// When the ROB retires a tID, the slot is freed and the stored ARID is read
// back combinationally for the R channel.
// -----------------------------------------------------------------------------
module rd_tid_alloc #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TID_WIDTH  = 4,
  parameter int MAX_OUTST  = 16   // legal range 1 .. 2**TID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,        // synchronous, active-low

  // AXI AR side
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,

  // Tagged request to tag compare
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [TID_WIDTH-1:0]  req_tid_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,

  // Retire from the ROB / R channel
  input  logic                  ret_valid_i,
  input  logic [TID_WIDTH-1:0]  ret_tid_i,
  output logic [ID_WIDTH-1:0]   ret_id_o,

  // Status
  output logic [TID_WIDTH:0]    outst_o,
  output logic                  err_o
);

  localparam int                   DEPTH   = 1 << TID_WIDTH;
  localparam logic [TID_WIDTH:0]   MAX_CNT = (TID_WIDTH+1)'(MAX_OUTST);
  localparam logic [TID_WIDTH:0]   CNT_ONE = (TID_WIDTH+1)'(1);
  localparam logic [TID_WIDTH-1:0] TID_ONE = TID_WIDTH'(1);

  typedef enum logic {
    S_IDLE = 1'b0,   // waiting for an AR request
    S_SEND = 1'b1    // presenting the tagged request to tag compare
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_next_state;

  logic [TID_WIDTH-1:0]  r_alloc_ptr;   // next tID to hand out
  logic [TID_WIDTH-1:0]  r_ret_ptr;     // next tID the ROB is expected to retire
  logic [TID_WIDTH:0]    r_outst;       // allocated but not yet retired
  logic [TID_WIDTH-1:0]  r_req_tid;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_err;

  logic [ID_WIDTH-1:0]   r_id_table [DEPTH];

  logic                  w_arready;
  logic                  w_req_valid;
  logic                  w_accept;
  logic                  w_ret_legal;
  logic                  w_ret_bad;
  logic                  w_room;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  // Room is judged on the registered count only, so a retire in the same cycle
  // re-opens arready one cycle later rather than through a comb path.
  assign w_room      = (r_outst < MAX_CNT);
  assign w_accept    = arvalid_i & w_arready;
  assign w_ret_legal = ret_valid_i & (r_outst != '0) & (ret_tid_i == r_ret_ptr);
  assign w_ret_bad   = ret_valid_i & ~w_ret_legal;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: one request in flight towards tag compare at a time.
  // NOTE: the default assignment at the top keeps this block free of latches
  // on any path that does not explicitly assign w_next_state.
  always_comb begin
    w_next_state = r_state;
    if (r_state == S_IDLE) begin
      if (w_accept) w_next_state = S_SEND;
    end else begin
      if (req_ready_i) w_next_state = S_IDLE;
    end
  end

  // Output decode; arready is forced low while reset is held.
  always_comb begin
    w_arready   = 1'b0;
    w_req_valid = 1'b0;
    if (r_state == S_IDLE) begin
      w_arready = rst_n & w_room;
    end else begin
      w_req_valid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Latch the tagged request on accept; held stable while in S_SEND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_tid  <= '0;
      r_req_addr <= '0;
    end else if (w_accept) begin
      r_req_tid  <= r_alloc_ptr;
      r_req_addr <= araddr_i;
    end
  end

  // Allocation pointer: advances by one per accept, wraps modulo 2**TID_WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_alloc_ptr <= TID_ONE;
    else if (w_accept) r_alloc_ptr <= r_alloc_ptr + TID_ONE;
  end

  // Retire pointer: advances by one per legal retire, same wrap as allocation.
  always_ff @(posedge clk) begin
    if (!rst_n)           r_ret_ptr <= TID_ONE;
    else if (w_ret_legal) r_ret_ptr <= r_ret_ptr + TID_ONE;
  end

  // Outstanding count: accept and legal retire together cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outst <= '0;
    end else begin
      case ({w_accept, w_ret_legal})
        2'b10:   r_outst <= r_outst + CNT_ONE;
        2'b01:   r_outst <= r_outst - CNT_ONE;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Sticky protocol error: any ignored retire pulse flags until reset.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_ret_bad) r_err <= 1'b1;
  end

  // ARID table write on accept.
  // NOTE: the table is intentionally not reset; an entry is always written on
  // accept before its tID can be legally retired, so stale contents are never
  // observed in correct operation and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) r_id_table[r_alloc_ptr] <= arid_i;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign arready_o   = w_arready;
  assign req_valid_o = w_req_valid;
  assign req_tid_o   = r_req_tid;
  assign req_addr_o  = r_req_addr;
  assign ret_id_o    = r_id_table[ret_tid_i];
  assign outst_o     = r_outst;
  assign err_o       = r_err;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_outst_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_outst <= MAX_CNT);

  a_no_accept_in_send : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_SEND) |-> !w_accept);

endmodule

// File: tb/tb_rd_tid_alloc.sv
// -----------------------------------------------------------------------------
// Testbench for rd_tid_alloc (TID_WIDTH=3, MAX_OUTST=4).
// Directed vector table, hand-written wrap / error / reset sequences, then
// random traffic checked every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_rd_tid_alloc;

  localparam int IDW  = 4;
  localparam int AW   = 16;
  localparam int TW   = 3;
  localparam int MAXO = 4;

  logic            clk;
  logic            rst_n;
  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic            req_valid;
  logic            req_ready;
  logic [TW-1:0]   req_tid;
  logic [AW-1:0]   req_addr;
  logic            ret_valid;
  logic [TW-1:0]   ret_tid;
  logic [IDW-1:0]  ret_id;
  logic [TW:0]     outst;
  logic            err;

  rd_tid_alloc #(
    .ID_WIDTH  (IDW),
    .ADDR_WIDTH(AW),
    .TID_WIDTH (TW),
    .MAX_OUTST (MAXO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arvalid_i  (arvalid),
    .arready_o  (arready),
    .arid_i     (arid),
    .araddr_i   (araddr),
    .req_valid_o(req_valid),
    .req_ready_i(req_ready),
    .req_tid_o  (req_tid),
    .req_addr_o (req_addr),
    .ret_valid_i(ret_valid),
    .ret_tid_i  (ret_tid),
    .ret_id_o   (ret_id),
    .outst_o    (outst),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: outstanding reads as an ordered list of {tid, id}
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [TW-1:0]  tid;
    logic [IDW-1:0] id;
  } entry_t;

  entry_t         m_q[$];
  logic [TW-1:0]  m_alloc, m_ret, m_tid;
  logic [AW-1:0]  m_addr;
  logic           m_pend, m_err, m_known;

  task automatic model_reset();
    m_q.delete();
    m_alloc = 1; m_ret = 1; m_tid = 0; m_addr = 0;
    m_pend = 0; m_err = 0; m_known = 1;
  endtask

  task automatic apply(input logic av, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                       input logic rr, input logic rv, input logic [TW-1:0] rtid, input logic rn);
    arvalid = av; arid = id; araddr = addr;
    req_ready = rr; ret_valid = rv; ret_tid = rtid; rst_n = rn;
    #1;
  endtask

  // Compare against the model, take one clock edge, advance the model.
  task automatic step();
    logic e_ar, acc, legal;
    int   idx;
    e_ar = rst_n && !m_pend && (m_q.size() < MAXO);
    if (m_known) begin
      check("arready",   32'(arready),   32'(e_ar));
      check("req_valid", 32'(req_valid), 32'(m_pend));
      check("req_tid",   32'(req_tid),   32'(m_tid));
      check("req_addr",  32'(req_addr),  32'(m_addr));
      check("outst",     32'(outst),     32'(m_q.size()));
      check("err",       32'(err),       32'(m_err));
      if (ret_valid && rst_n) begin
        idx = -1;
        foreach (m_q[i]) if (m_q[i].tid == ret_tid) idx = i;
        if (idx >= 0) check("ret_id", 32'(ret_id), 32'(m_q[idx].id));
      end
    end
    acc   = arvalid && e_ar;
    legal = ret_valid && (m_q.size() != 0) && (ret_tid == m_ret);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (legal) begin
        void'(m_q.pop_front());
        m_ret = m_ret + 1'b1;
      end else if (ret_valid) begin
        m_err = 1;
      end
      if (acc) begin
        m_q.push_back('{tid: m_alloc, id: arid});
        m_tid   = m_alloc;
        m_addr  = araddr;
        m_alloc = m_alloc + 1'b1;
        m_pend  = 1;
      end else if (m_pend && req_ready) begin
        m_pend = 0;
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic           av;
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic           rr;
    logic           rv;
    logic [TW-1:0]  rtid;
    logic           e_ar;
    logic           e_rv;
    logic [TW-1:0]  e_tid;
    logic [AW-1:0]  e_addr;
    logic [TW:0]    e_outst;
    logic           e_err;
    logic [IDW-1:0] e_rid;
  } vec_t;

  function automatic vec_t mk(logic av, logic [IDW-1:0] id, logic [AW-1:0] addr, logic rr,
                              logic rv, logic [TW-1:0] rtid, logic e_ar, logic e_rv,
                              logic [TW-1:0] e_tid, logic [AW-1:0] e_addr, logic [TW:0] e_outst,
                              logic e_err, logic [IDW-1:0] e_rid);
    vec_t v;
    v.av = av; v.id = id; v.addr = addr; v.rr = rr; v.rv = rv; v.rtid = rtid;
    v.e_ar = e_ar; v.e_rv = e_rv; v.e_tid = e_tid; v.e_addr = e_addr;
    v.e_outst = e_outst; v.e_err = e_err; v.e_rid = e_rid;
    return v;
  endfunction

  vec_t vecs[19];

  logic [TW-1:0] wrap_tids[10];

  initial begin
    //              av id  addr     rr rv rt  | ar rv tid addr     out err rid
    vecs[0]  = mk(1, 5, 16'h100, 0, 0, 0,   1, 0, 0, 16'h000, 0, 0, 0);  // first AR
    vecs[1]  = mk(0, 0, 16'h000, 0, 0, 0,   0, 1, 1, 16'h100, 1, 0, 0);  // held
    vecs[2]  = mk(0, 0, 16'h000, 0, 0, 0,   0, 1, 1, 16'h100, 1, 0, 0);
    vecs[3]  = mk(0, 0, 16'h000, 0, 0, 0,   0, 1, 1, 16'h100, 1, 0, 0);
    vecs[4]  = mk(0, 0, 16'h000, 1, 0, 0,   0, 1, 1, 16'h100, 1, 0, 0);  // handshake
    vecs[5]  = mk(1, 6, 16'h200, 0, 0, 0,   1, 0, 1, 16'h100, 1, 0, 0);
    vecs[6]  = mk(0, 0, 16'h000, 1, 0, 0,   0, 1, 2, 16'h200, 2, 0, 0);
    vecs[7]  = mk(1, 7, 16'h300, 0, 0, 0,   1, 0, 2, 16'h200, 2, 0, 0);
    vecs[8]  = mk(0, 0, 16'h000, 1, 0, 0,   0, 1, 3, 16'h300, 3, 0, 0);
    vecs[9]  = mk(1, 8, 16'h400, 0, 0, 0,   1, 0, 3, 16'h300, 3, 0, 0);
    vecs[10] = mk(0, 0, 16'h000, 1, 0, 0,   0, 1, 4, 16'h400, 4, 0, 0);
    vecs[11] = mk(1, 9, 16'h500, 0, 1, 1,   0, 0, 4, 16'h400, 4, 0, 5);  // full + retire
    vecs[12] = mk(1, 9, 16'h500, 0, 0, 0,   1, 0, 4, 16'h400, 3, 0, 0);  // re-opened
    vecs[13] = mk(0, 0, 16'h000, 1, 0, 0,   0, 1, 5, 16'h500, 4, 0, 0);
    vecs[14] = mk(0, 0, 16'h000, 0, 1, 2,   0, 0, 5, 16'h500, 4, 0, 6);
    vecs[15] = mk(1,10, 16'h600, 0, 1, 3,   1, 0, 5, 16'h500, 3, 0, 7);  // accept+retire
    vecs[16] = mk(0, 0, 16'h000, 1, 0, 0,   0, 1, 6, 16'h600, 3, 0, 0);  // outst unchanged
    vecs[17] = mk(0, 0, 16'h000, 0, 1, 5,   1, 0, 6, 16'h600, 3, 0, 9);  // out-of-order
    vecs[18] = mk(0, 0, 16'h000, 0, 0, 0,   1, 0, 6, 16'h600, 3, 1, 0);  // err sticky

    foreach (wrap_tids[k]) wrap_tids[k] = TW'(k + 1);

    m_known = 0;
    m_q.delete();
    m_alloc = 1; m_ret = 1; m_tid = 0; m_addr = 0; m_pend = 0; m_err = 0;

    // Reset for two cycles
    apply(0, 0, 0, 0, 0, 0, 0); step();
    apply(0, 0, 0, 0, 0, 0, 0); step();

    // Directed table
    foreach (vecs[i]) begin
      apply(vecs[i].av, vecs[i].id, vecs[i].addr, vecs[i].rr, vecs[i].rv, vecs[i].rtid, 1);
      check($sformatf("vec%0d_arready", i),   32'(arready),   32'(vecs[i].e_ar));
      check($sformatf("vec%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].e_rv));
      check($sformatf("vec%0d_req_tid", i),   32'(req_tid),   32'(vecs[i].e_tid));
      check($sformatf("vec%0d_req_addr", i),  32'(req_addr),  32'(vecs[i].e_addr));
      check($sformatf("vec%0d_outst", i),     32'(outst),     32'(vecs[i].e_outst));
      check($sformatf("vec%0d_err", i),       32'(err),       32'(vecs[i].e_err));
      if (vecs[i].rv) check($sformatf("vec%0d_ret_id", i), 32'(ret_id), 32'(vecs[i].e_rid));
      step();
    end

    // One-cycle reset clears the sticky error
    apply(0, 0, 0, 0, 0, 0, 0); step();
    check("rst_err_clear", 32'(err),   0);
    check("rst_outst",     32'(outst), 0);

    // tID wrap: 10 requests issued and retired in order
    for (int k = 0; k < 10; k++) begin
      apply(1, IDW'(k), AW'(k * 16), 0, 0, 0, 1); step();
      check("wrap_tid", 32'(req_tid), 32'(wrap_tids[k]));
      apply(0, 0, 0, 1, 1, wrap_tids[k], 1); step();
    end
    check("wrap_err",   32'(err),   0);
    check("wrap_outst", 32'(outst), 0);

    // Retire with nothing outstanding
    apply(0, 0, 0, 0, 1, 3, 1); step();
    check("empty_ret_err",   32'(err),   1);
    check("empty_ret_outst", 32'(outst), 0);
    apply(0, 0, 0, 0, 0, 0, 1); step();
    check("empty_ret_sticky", 32'(err), 1);

    // Reset restores alloc_ptr to 1
    apply(0, 0, 0, 0, 0, 0, 0); step();
    check("rst2_err", 32'(err), 0);
    apply(1, 4'h3, 16'hBEEF, 0, 0, 0, 1); step();
    check("rst2_first_tid", 32'(req_tid), 1);
    apply(0, 0, 0, 1, 0, 0, 1); step();

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic          rv, rn;
      logic [TW-1:0] rt;
      rv = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 15) == 0) ? TW'($urandom) : m_ret;
      rn = ($urandom_range(0, 499) != 0);
      apply(1'($urandom), IDW'($urandom), AW'($urandom), 1'($urandom), rv, rt, rn);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
